mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data port arbiter onto one shared memory port, one transaction in flight
// Optional grant/contention counters: define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           if_grant_cnt,
  output logic [31:0]           d_grant_cnt,
  output logic [31:0]           contention_cnt
`endif
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  state_t          state_next;
  logic            owner_d;
  logic [SW-1:0]   starve_cnt;
  logic            grant_if;
  logic            grant_d;
  logic            contend;

  // Every output is forced low while reset is held, including the combinational grant path.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_d    = 1'b0;
    contend    = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          contend = if_req && d_req;
          if (d_req && !(contend && starve_cnt == STARVE_MAX)) begin
            grant_d = 1'b1;
          end else if (if_req) begin
            grant_if = 1'b1;
          end
          if (grant_d || grant_if) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_next = IDLE;
            if (owner_d) begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
    if_gnt    = grant_if;
    d_gnt     = grant_d;
    mem_req   = grant_if | grant_d;
    mem_we    = grant_d & d_we;
    mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
    mem_wdata = grant_d ? d_wdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state <= state_next;
      if (grant_d || grant_if) begin
        owner_d <= grant_d;
      end
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (grant_d && contend && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_grant_cnt   <= '0;
      d_grant_cnt    <= '0;
      contention_cnt <= '0;
    end else begin
      if (grant_if) if_grant_cnt <= if_grant_cnt + 32'd1;
      if (grant_d) d_grant_cnt <= d_grant_cnt + 32'd1;
      if (contend) contention_cnt <= contention_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int OW = 6 + 4 * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [DW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [DW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   if_grant_cnt;
  logic [31:0]   d_grant_cnt;
  logic [31:0]   contention_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int wins   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .if_grant_cnt(if_grant_cnt), .d_grant_cnt(d_grant_cnt), .contention_cnt(contention_cnt)
`endif
  );

  wire [OW-1:0] obs = {if_gnt, d_gnt, mem_req, mem_we, mem_addr, mem_wdata,
                       if_rvalid, if_rdata, d_rvalid, d_rdata};

  function automatic logic [OW-1:0] pack(input logic gi, input logic gd, input logic we,
                                         input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                                         input logic ir, input logic [DW-1:0] ird,
                                         input logic dr, input logic [DW-1:0] drd);
    return {gi, gd, gi | gd, we, addr, wd, ir, ird, dr, drd};
  endfunction

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wins = 0;
  endtask

  task automatic test_reset();
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; d_we = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got %h expected 0", obs); end
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL idle_after_reset got %h expected 0", obs); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    logic [OW-1:0] e;
    if_req = 1'b1; if_addr = 32'h100;
    e = pack(1'b1, 1'b0, 1'b0, 32'h100, '0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL fetch_grant got %h expected %h", obs, e); end
    @(posedge clk); #1;
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    e = pack(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL fetch_resp got %h expected %h", obs, e); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    wins = 0;
  endtask

  task automatic test_data_write();
    logic [OW-1:0] e;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55;
    e = pack(1'b0, 1'b1, 1'b1, 32'h40, 32'h55, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL write_grant got %h expected %h", obs, e); end
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    e = pack(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL write_ack got %h expected %h", obs, e); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic test_contention();
    logic [OW-1:0] e;
    logic want_if;
    pulse_reset();
    if_req = 1'b1; if_addr = 32'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = '0;
    for (int k = 0; k < 10; k++) begin
      want_if = (wins == SL);
      wins = want_if ? 0 : ((wins < SL) ? wins + 1 : SL);
      mem_rvalid = 1'b0;
      e = want_if ? pack(1'b1, 1'b0, 1'b0, 32'h1000, '0, 1'b0, '0, 1'b0, '0)
                  : pack(1'b0, 1'b1, 1'b0, 32'h2000, '0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL contention_grant_%0d got %h expected %h", k, obs, e); end
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      e = want_if ? pack(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, mem_rdata, 1'b0, '0)
                  : pack(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, mem_rdata);
      @(negedge clk);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL contention_resp_%0d got %h expected %h", k, obs, e); end
      @(posedge clk); #1;
    end
    idle_inputs();
`ifdef ARB_PERF_CNT_EN
    @(negedge clk);
    checks++;
    if (if_grant_cnt !== 32'd2) begin errors++; $display("FAIL perf_if_grants got %0d expected 2", if_grant_cnt); end
    checks++;
    if (d_grant_cnt !== 32'd8) begin errors++; $display("FAIL perf_d_grants got %0d expected 8", d_grant_cnt); end
    checks++;
    if (contention_cnt !== 32'd10) begin errors++; $display("FAIL perf_contention got %0d expected 10", contention_cnt); end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_latency3();
    logic [OW-1:0] e;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    e = pack(1'b0, 1'b1, 1'b0, 32'h200, '0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lat3_grant got %h expected %h", obs, e); end
    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h300;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL lat3_wait_%0d got %h expected 0", k, obs); end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0003;
    e = pack(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'hCAFE_0003);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lat3_resp got %h expected %h", obs, e); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    e = pack(1'b1, 1'b0, 1'b0, 32'h300, '0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lat3_second_grant got %h expected %h", obs, e); end
    @(posedge clk); #1;
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    e = pack(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 32'h0BAD_F00D, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lat3_second_resp got %h expected %h", obs, e); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    wins = 0;
  endtask

  task automatic test_reset_mid_wait();
    logic [OW-1:0] e;
    if_req = 1'b1; if_addr = 32'h300;
    e = pack(1'b1, 1'b0, 1'b0, 32'h300, '0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_wait_grant got %h expected %h", obs, e); end
    @(posedge clk); #1;
    if_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL rst_wait_in_reset got %h expected 0", obs); end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL rst_wait_stale_resp got %h expected 0", obs); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h66;
    e = pack(1'b0, 1'b1, 1'b1, 32'h44, 32'h66, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_wait_regrant got %h expected %h", obs, e); end
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    e = pack(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'hA5A5_A5A5);
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rst_wait_reack got %h expected %h", obs, e); end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    wins = 0;
  endtask

  task automatic test_random();
    logic [OW-1:0] e;
    logic busy, own_d, gi, gd, rv_i, rv_d;
    int lat, n_if, n_d, n_c;
    busy = 1'b0; own_d = 1'b0; lat = 0; n_if = 0; n_d = 0; n_c = 0;
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_rdata  = $urandom;
      mem_rvalid = busy ? (lat == 1) : ($urandom_range(0, 5) == 0);
      gi = 1'b0; gd = 1'b0;
      if (busy) begin
        rv_i = mem_rvalid && !own_d;
        rv_d = mem_rvalid && own_d;
        e = pack(1'b0, 1'b0, 1'b0, '0, '0, rv_i, rv_i ? mem_rdata : '0, rv_d, rv_d ? mem_rdata : '0);
      end else begin
        if (if_req && d_req) n_c++;
        gd = d_req && !(if_req && wins == SL);
        gi = if_req && !gd;
        e = pack(gi, gd, gd & d_we, gd ? d_addr : (gi ? if_addr : '0), gd ? d_wdata : '0,
                 1'b0, '0, 1'b0, '0);
      end
      @(negedge clk);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL random_cycle_%0d got %h expected %h", c, obs, e); end
      @(posedge clk); #1;
      if (busy) begin
        if (mem_rvalid) busy = 1'b0;
        else lat--;
      end else if (gi || gd) begin
        busy = 1'b1; own_d = gd; lat = $urandom_range(1, 3);
        if (gi) begin
          if_req = 1'b0; wins = 0; n_if++;
        end else begin
          d_req = 1'b0; n_d++;
          if (if_req) wins = (wins < SL) ? wins + 1 : SL;
        end
      end
    end
    idle_inputs();
`ifdef ARB_PERF_CNT_EN
    @(negedge clk);
    checks++;
    if (if_grant_cnt !== 32'(n_if)) begin errors++; $display("FAIL rand_perf_if got %0d expected %0d", if_grant_cnt, n_if); end
    checks++;
    if (d_grant_cnt !== 32'(n_d)) begin errors++; $display("FAIL rand_perf_d got %0d expected %0d", d_grant_cnt, n_d); end
    checks++;
    if (contention_cnt !== 32'(n_c)) begin errors++; $display("FAIL rand_perf_cont got %0d expected %0d", contention_cnt, n_c); end
    @(posedge clk); #1;
`else
    if (n_if + n_d + n_c < 0) $display("unreachable");
`endif
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_fetch();
    test_data_write();
    test_contention();
    test_latency3();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
